// File: rtl/alu_seq.sv
// Sequential command initiator wrapped around the combinational alu block:
// holds a signed accumulator, runs one command at a time, returns each result.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [2:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [2:0]       OP_DIV  = 3'b011;
    localparam logic [2:0]       OP_MOD  = 3'b100;
    localparam logic [2:0]       OP_PASS = 3'b101;
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] data_r;
    logic [2:0]       op_r;
    logic             load_r;

    logic [WIDTH-1:0] new_acc_s;
    logic             new_err_s;
    logic             new_zero_s;

    // The ALU leaves divide/modulo by zero undefined, so those are refused here.
    function automatic logic div_by_zero(input logic [2:0] op, input logic [WIDTH-1:0] d);
        return ((op == OP_DIV) || (op == OP_MOD)) && (d == ZERO_W);
    endfunction

    assign cmd_ready = (state_r == IDLE);

    // Result selection for the command currently in EXEC
    always_comb begin
        new_acc_s  = acc_r;
        new_err_s  = 1'b0;
        new_zero_s = (acc_r == ZERO_W);
        if (load_r) begin
            new_acc_s  = data_r;
            new_err_s  = 1'b0;
            new_zero_s = (data_r == ZERO_W);
        end else if (div_by_zero(op_r, data_r)) begin
            new_acc_s  = acc_r;
            new_err_s  = 1'b1;
            new_zero_s = (acc_r == ZERO_W);
        end else begin
            new_acc_s  = alu_c;
            new_err_s  = 1'b0;
            new_zero_s = alu_z;
        end
    end

    // Command FSM, accumulator, response registers and registered ALU drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            acc_r     <= ZERO_W;
            data_r    <= ZERO_W;
            op_r      <= 3'b000;
            load_r    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_acc   <= ZERO_W;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            alu_sel   <= OP_PASS;
            alu_a     <= ZERO_W;
            alu_b     <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        load_r  <= cmd_load;
                        op_r    <= cmd_op;
                        data_r  <= cmd_data;
                        alu_sel <= cmd_op;
                        alu_a   <= acc_r;
                        alu_b   <= cmd_data;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    acc_r     <= new_acc_s;
                    rsp_acc   <= new_acc_s;
                    rsp_zero  <= new_zero_s;
                    rsp_err   <= new_err_s;
                    rsp_valid <= 1'b1;
                    // Park the ALU on pass-A of the new accumulator between commands
                    alu_sel   <= OP_PASS;
                    alu_a     <= new_acc_s;
                    alu_b     <= ZERO_W;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    alu_sel   <= OP_PASS;
                    alu_a     <= acc_r;
                    alu_b     <= ZERO_W;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
